// File: rtl/uart_dev.sv
`default_nettype none
// ============================================================================
// Module      : uart_dev
// Description : Memory-mapped 8N1 UART slave for one MMU device slot.
//               TX FIFO with a shift FSM, single-byte RX holding register,
//               programmable bit divisor and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_dev #(
  parameter int unsigned TX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TX_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Register file and flag state
  logic [15:0] div_q, div_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        irq_q, irq_d;

  // TX FIFO
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic        fifo_push, fifo_pop, tx_empty, tx_full;

  // TX engine
  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_busy;

  // RX engine
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_done, rx_stop_ok;

  // Decode and helpers
  logic        sel_ok, sel_data, sel_stat, sel_div, sel_ctrl;
  logic        data_rd_fire, stat_rd_fire;
  logic [15:0] div_eff, rx_half;
  logic [16:0] div_p1;
  logic        unused_wd;

  assign unused_wd = &{1'b0, wd[31:16]};

  // A divisor below 2 would leave no room for a mid-bit RX sample.
  assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;
  assign div_p1  = {1'b0, div_eff} + 17'd1;
  assign rx_half = div_p1[16:1] - 16'd1;

  assign sel_ok   = (addr[29:2] == 28'd0);
  assign sel_data = sel_ok && (addr[1:0] == 2'd0);
  assign sel_stat = sel_ok && (addr[1:0] == 2'd1);
  assign sel_div  = sel_ok && (addr[1:0] == 2'd2);
  assign sel_ctrl = sel_ok && (addr[1:0] == 2'd3);
  assign data_rd_fire = re && sel_data;
  assign stat_rd_fire = re && sel_stat;

  assign tx_empty  = (count_q == '0);
  assign tx_full   = (count_q == FULL_CNT);
  assign fifo_push = we && sel_data && !tx_full;
  assign tx_busy   = (tx_state_q != ST_IDLE);

  assign tx  = tx_q;
  assign irq = irq_q;

  // Combinational register read, independent of the read strobe
  always_comb begin
    rd = 32'd0;
    if (sel_data)      rd = {24'd0, rx_data_q};
    else if (sel_stat) rd = {26'd0, frame_err_q, tx_busy, rx_overrun_q,
                             rx_valid_q, tx_empty, tx_full};
    else if (sel_div)  rd = {16'd0, div_q};
    else if (sel_ctrl) rd = {30'd0, ctrl_q};
  end

  // FIFO storage; contents need no reset because reset clears the pointers
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= wd[7:0];
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = fifo_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // TX next-state: every state lasts div_eff+1 clocks; divisor sampled at reload
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q];
          tx_cnt_d   = div_eff;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = div_eff;
          tx_bit_d   = 3'd0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_eff;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!tx_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_mem[rd_ptr_q];
            tx_cnt_d   = div_eff;
            tx_state_d = ST_START;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // Line level registered from the next state so tx is glitch-free
    case (tx_state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // RX next-state: half-bit qualify of the start edge, then mid-bit sampling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_stop_ok = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = rx_half;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_sync_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_cnt_d   = div_eff;
            rx_bit_d   = 3'd0;
            rx_state_d = ST_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = div_eff;
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_done    = 1'b1;
          rx_stop_ok = rx_sync_q;
          rx_state_d = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // Register writes, read side effects and flag updates; new events win over clears
  always_comb begin
    div_d        = (we && sel_div)  ? wd[15:0] : div_q;
    ctrl_d       = (we && sel_ctrl) ? wd[1:0]  : ctrl_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = data_rd_fire ? 1'b0 : rx_valid_q;
    rx_overrun_d = stat_rd_fire ? 1'b0 : rx_overrun_q;
    frame_err_d  = stat_rd_fire ? 1'b0 : frame_err_q;
    if (rx_done) begin
      if (!rx_stop_ok) begin
        frame_err_d = 1'b1;
      end else if (!rx_valid_q || data_rd_fire) begin
        rx_data_d  = rx_shift_d;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end
    irq_d = (rx_valid_q && ctrl_q[0]) || (tx_empty && !tx_busy && ctrl_q[1]);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= DIV_RESET;
      ctrl_q       <= 2'd0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      irq_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tx_state_q   <= ST_IDLE;
      tx_cnt_q     <= 16'd0;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'd0;
      tx_q         <= 1'b1;
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= 16'd0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
    end else begin
      div_q        <= div_d;
      ctrl_q       <= ctrl_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
      irq_q        <= irq_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_dev
// Description : Self-checking bench for uart_dev. Serial TX bytes are decoded
//               by a monitor and compared against an expected-byte queue;
//               register and flag behaviour is checked with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_dev;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] addr = 30'd0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        tx;
  logic        rx = 1'b1;
  logic        irq;

  int vectors = 0;
  int misses  = 0;
  logic [7:0] tx_exp_q [$];
  bit  mon_en  = 1'b1;
  int  mon_bit = 4;

  uart_dev #(.TX_DEPTH(8), .DIV_RESET(16'd867)) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wd(wd),
    .rd(rd), .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wd = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_strobe(input logic [29:0] a);
    @(negedge clk);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic peek(input logic [29:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  // RX frame at DIV=7 (8 clocks per bit)
  task automatic send_rx(input logic [7:0] b, input logic stopb);
    @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = stopb;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Serial TX monitor: decodes mid-bit and scores against the expected queue
  initial begin : tx_monitor
    logic [7:0] b;
    logic       sb;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        repeat (mon_bit / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_bit) @(negedge clk);
          b[i] = tx;
        end
        repeat (mon_bit) @(negedge clk);
        sb = tx;
        if (tx_exp_q.size() == 0) begin
          vectors++;
          misses++;
          $display("FAIL tx_byte: got 0x%02h, no byte expected", b);
        end else begin
          check("tx_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
        end
        check("tx_stop", {31'd0, sb}, 32'd1);
      end
    end
  end

  initial begin : stim
    logic [31:0] v;
    logic [39:0] seq;
    logic [9:0]  frm;
    int          n;
    bit          done;
    bit          saw_low;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    peek(30'd1, v); check("rst_status", v, 32'h02);
    peek(30'd0, v); check("rst_data", v, 32'h00);
    peek(30'd2, v); check("rst_div", v, 32'd867);
    peek(30'd3, v); check("rst_ctrl", v, 32'h0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Divisor write and readback; upper bits read zero
    wr(30'd2, 32'hFFFF_0003);
    peek(30'd2, v); check("div_rb", v, 32'h3);

    // Single byte 0xA5: exact waveform and busy length
    tx_exp_q.push_back(8'hA5);
    wr(30'd0, 32'h0000_00A5);
    frm = {1'b1, 8'hA5, 1'b0};
    seq = '0;
    n   = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      peek(30'd1, v);
      if (v[4]) begin
        if (n < 40) seq[n] = tx;
        n++;
      end
    end
    check("a5_busy_clocks", n, 40);
    for (int k = 0; k < 10; k++)
      check("a5_bit", {28'd0, seq[4*k +: 4]}, {28'd0, {4{frm[k]}}});

    // Ten back-to-back pushes: first pops immediately, ninth fits, tenth dropped
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_exp_q.push_back(8'(8'h10 + i));
      @(negedge clk);
      addr = 30'd0; wd = 32'(8'h10 + i); we = 1'b1;
    end
    @(negedge clk);
    we = 1'b0;
    peek(30'd1, v); check("burst_full", v, 32'h11);
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      peek(30'd1, v);
      if (!v[4] && v[1]) done = 1'b1;
    end
    check("burst_drain", {31'd0, done}, 32'd1);
    repeat (10) @(negedge clk);

    // irq from tx idle+empty, one cycle after CTRL lands
    wr(30'd3, 32'h3);
    check("irq_pre", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    peek(30'd3, v); check("ctrl_rb", v, 32'h3);
    wr(30'd3, 32'h0);
    @(negedge clk);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // RX 0x3C at DIV=7
    wr(30'd2, 32'h7);
    send_rx(8'h3C, 1'b1);
    peek(30'd1, v); check("rx_valid", v, 32'h06);
    peek(30'd0, v); check("rx_data", v, 32'h3C);
    repeat (5) @(negedge clk);
    peek(30'd1, v); check("rx_peek_noeffect", v, 32'h06);
    rd_strobe(30'd0);
    peek(30'd1, v); check("rx_read_clr", v, 32'h02);

    // Overrun: second byte dropped, first kept
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    peek(30'd0, v); check("ovr_data", v, 32'h11);
    peek(30'd1, v); check("ovr_status", v, 32'h0E);
    rd_strobe(30'd1);
    peek(30'd1, v); check("ovr_clr", v, 32'h06);
    rd_strobe(30'd0);
    peek(30'd1, v); check("ovr_data_clr", v, 32'h02);

    // Framing error: byte discarded, rx_valid untouched
    send_rx(8'h55, 1'b0);
    peek(30'd1, v); check("ferr_status", v, 32'h22);
    peek(30'd0, v); check("ferr_data", v, 32'h11);
    rd_strobe(30'd1);
    peek(30'd1, v); check("ferr_clr", v, 32'h02);

    // One-clock glitch is rejected
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (30) @(negedge clk);
    peek(30'd1, v); check("glitch", v, 32'h02);

    // Reset mid-frame with a byte still queued
    mon_en = 1'b0;
    wr(30'd0, 32'h5A);
    wr(30'd0, 32'h5B);
    repeat (20) @(negedge clk);
    peek(30'd1, v); check("midtx_busy", v, 32'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    peek(30'd1, v); check("rst_mid_status", v, 32'h02);
    saw_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("flush_quiet", {31'd0, saw_low}, 32'd0);
    mon_en = 1'b1;

    // Out-of-map accesses: no writes, no pushes, read zero
    wr(30'h6, 32'h5);
    peek(30'd2, v); check("unmap_div", v, 32'd867);
    peek(30'h6, v); check("unmap_rd", v, 32'h0);
    wr(30'h4, 32'h41);
    @(negedge clk);
    peek(30'd1, v); check("unmap_push", v, 32'h02);

    check("tx_queue_empty", tx_exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
`default_nettype wire
